// File: rtl/vga_timing_pkg.sv
// Shared definitions for the VGA sync timing detector.
//   det_state_t          : detector FSM state encoding
//   DEFAULT_COUNTER_SIZE : default width of counters and measurement outputs
//   SYNC_POL_ACTIVE_*    : values for the SYNC_ACTIVE_LOW parameter
package vga_timing_pkg;

    localparam int DEFAULT_COUNTER_SIZE = 11;

    localparam bit SYNC_POL_ACTIVE_LOW  = 1'b1;
    localparam bit SYNC_POL_ACTIVE_HIGH = 1'b0;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } det_state_t;

endpackage

// File: rtl/sync_edge_detector.sv
// Brings one raw sync pin into the control_clock domain, normalises it so
// that 1 means "sync active", and emits single-cycle edge pulses.
// Ports:
//   control_clock   : pixel clock
//   control_reset_n : asynchronous active-low reset
//   i_sync          : raw sync pin (asynchronous)
//   o_lead          : one-cycle pulse on inactive->active
//   o_trail         : one-cycle pulse on active->inactive
// Pin change to edge pulse is two clock edges; the pulse is consumed on the
// third edge.
module sync_edge_detector
    import vga_timing_pkg::*;
#(
    parameter bit SYNC_ACTIVE_LOW = SYNC_POL_ACTIVE_LOW
)(
    input  logic control_clock,
    input  logic control_reset_n,
    input  logic i_sync,
    output logic o_lead,
    output logic o_trail
);

    logic w_pin_active;
    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Normalising before the first flop lets every flop reset to "inactive"
    // regardless of polarity, so reset release never fakes an edge.
    assign w_pin_active = (SYNC_ACTIVE_LOW == SYNC_POL_ACTIVE_HIGH) ? i_sync : ~i_sync;

    always_ff @(posedge control_clock or negedge control_reset_n) begin
        if (!control_reset_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= w_pin_active;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_lead  =  r_sync & ~r_prev;
    assign o_trail = ~r_sync &  r_prev;

endmodule

// File: rtl/vga_sync_timing_detector.sv
// Receive-side VGA timing detector. Measures line length, h_sync width and
// lines per frame from an incoming h_sync/v_sync pair, locks once the timing
// repeats for LOCK_FRAMES frames, and reports pixel coordinates relative to
// the sync leading edges.
// Ports:
//   control_clock, control_reset_n : pixel clock, async active-low reset
//   h_sync, v_sync                 : raw sync pins
//   locked, lock_lost, frame_start : status / one-cycle pulses
//   line_length, h_sync_width,
//   frame_lines                    : last captured measurements
//   pixel_x, pixel_y               : live coordinates, valid while locked
// Build option: define VGA_SYNC_TIMEOUT_EN to drop out of MEASURE/LOCKED when
// the line counter saturates (h_sync lost).
//
// state   | meaning
// SEARCH  | waiting for the first frame start
// MEASURE | building a reference and counting matching frames
// LOCKED  | timing matches reference, coordinates valid
module vga_sync_timing_detector
    import vga_timing_pkg::*;
#(
    parameter int COUNTER_SIZE    = DEFAULT_COUNTER_SIZE,
    parameter int LOCK_FRAMES     = 2,
    parameter bit SYNC_ACTIVE_LOW = SYNC_POL_ACTIVE_LOW
)(
    input  logic                    control_clock,
    input  logic                    control_reset_n,
    input  logic                    h_sync,
    input  logic                    v_sync,
    output logic                    locked,
    output logic                    lock_lost,
    output logic                    frame_start,
    output logic [COUNTER_SIZE-1:0] line_length,
    output logic [COUNTER_SIZE-1:0] h_sync_width,
    output logic [COUNTER_SIZE-1:0] frame_lines,
    output logic [COUNTER_SIZE-1:0] pixel_x,
    output logic [COUNTER_SIZE-1:0] pixel_y
);

    localparam logic [COUNTER_SIZE-1:0] CNT_MAX = '1;
    // The reference frame is the first of the LOCK_FRAMES matching frames,
    // so only LOCK_FRAMES-1 further matches are counted.
    localparam logic [3:0] LOCK_TARGET = 4'(LOCK_FRAMES - 1);

    logic w_h_lead;
    logic w_h_trail;
    logic w_v_lead;
    logic w_unused_v_trail;

    sync_edge_detector #(.SYNC_ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_h_edge (
        .control_clock   (control_clock),
        .control_reset_n (control_reset_n),
        .i_sync          (h_sync),
        .o_lead          (w_h_lead),
        .o_trail         (w_h_trail)
    );

    sync_edge_detector #(.SYNC_ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_v_edge (
        .control_clock   (control_clock),
        .control_reset_n (control_reset_n),
        .i_sync          (v_sync),
        .o_lead          (w_v_lead),
        .o_trail         (w_unused_v_trail)
    );

    logic [COUNTER_SIZE-1:0] r_h_counter;
    logic [COUNTER_SIZE-1:0] r_v_counter;
    logic                    r_v_pending;
    logic [COUNTER_SIZE-1:0] w_h_inc;
    logic [COUNTER_SIZE-1:0] w_v_inc;
    logic                    w_frame_edge;

    det_state_t              r_state;
    logic [3:0]              r_match_count;
    logic [3:0]              w_match_next;
    logic                    r_ref_valid;
    logic [COUNTER_SIZE-1:0] r_ref_len;
    logic [COUNTER_SIZE-1:0] r_ref_lines;
    logic                    r_first_valid;
    logic [COUNTER_SIZE-1:0] r_first_len;
    logic                    r_line_bad;
    logic                    w_frame_good;

    // w_h_inc / w_v_inc are also the values captured on an edge this cycle.
    assign w_h_inc      = (r_h_counter == CNT_MAX) ? CNT_MAX : r_h_counter + 1'b1;
    assign w_v_inc      = (r_v_counter == CNT_MAX) ? CNT_MAX : r_v_counter + 1'b1;
    assign w_frame_edge = w_h_lead & (r_v_pending | w_v_lead);
    assign w_match_next = r_match_count + 4'd1;
    // The capture taken at the frame-start line closes the old frame, so it
    // is included in that frame's stability verdict.
    assign w_frame_good = ~r_line_bad & ~(r_first_valid & (w_h_inc != r_first_len));

`ifdef VGA_SYNC_TIMEOUT_EN
    logic w_h_sat;
    assign w_h_sat = (r_h_counter == CNT_MAX);
`endif

    always_ff @(posedge control_clock or negedge control_reset_n) begin
        if (!control_reset_n) begin
            r_h_counter  <= '0;
            r_v_counter  <= '0;
            r_v_pending  <= 1'b0;
            line_length  <= '0;
            h_sync_width <= '0;
            frame_lines  <= '0;
            frame_start  <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (w_h_lead) begin
                r_h_counter <= '0;
                line_length <= w_h_inc;
            end else begin
                r_h_counter <= w_h_inc;
            end
            if (w_h_trail) begin
                h_sync_width <= w_h_inc;
            end
            if (w_frame_edge) begin
                frame_lines <= w_v_inc;
                r_v_counter <= '0;
                r_v_pending <= 1'b0;
                frame_start <= 1'b1;
            end else begin
                if (w_h_lead) begin
                    r_v_counter <= w_v_inc;
                end
                if (w_v_lead) begin
                    r_v_pending <= 1'b1;
                end
            end
`ifdef VGA_SYNC_TIMEOUT_EN
            if (w_h_sat && r_state != SEARCH) begin
                r_v_pending <= 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge control_clock or negedge control_reset_n) begin
        if (!control_reset_n) begin
            r_state       <= SEARCH;
            r_match_count <= '0;
            r_ref_valid   <= 1'b0;
            r_ref_len     <= '0;
            r_ref_lines   <= '0;
            r_first_valid <= 1'b0;
            r_first_len   <= '0;
            r_line_bad    <= 1'b0;
            locked        <= 1'b0;
            lock_lost     <= 1'b0;
        end else begin
            lock_lost <= 1'b0;

            if (w_frame_edge) begin
                r_first_valid <= 1'b0;
                r_line_bad    <= 1'b0;
            end else if (w_h_lead) begin
                if (!r_first_valid) begin
                    r_first_len   <= w_h_inc;
                    r_first_valid <= 1'b1;
                end else if (w_h_inc != r_first_len) begin
                    r_line_bad <= 1'b1;
                end
            end

            case (r_state)
                SEARCH: begin
                    if (w_frame_edge) begin
                        r_state       <= MEASURE;
                        r_match_count <= '0;
                        r_ref_valid   <= 1'b0;
                    end
                end
                MEASURE: begin
                    if (w_frame_edge) begin
                        if (r_ref_valid && w_frame_good &&
                            w_h_inc == r_ref_len && w_v_inc == r_ref_lines) begin
                            r_match_count <= w_match_next;
                            if (w_match_next >= LOCK_TARGET) begin
                                r_state <= LOCKED;
                                locked  <= 1'b1;
                            end
                        end else begin
                            r_match_count <= '0;
                            r_ref_valid   <= 1'b1;
                            r_ref_len     <= w_h_inc;
                            r_ref_lines   <= w_v_inc;
                            if (LOCK_TARGET == 4'd0) begin
                                r_state <= LOCKED;
                                locked  <= 1'b1;
                            end
                        end
                    end
                end
                LOCKED: begin
                    if (w_h_lead && ((w_h_inc != r_ref_len) ||
                                     (w_frame_edge && w_v_inc != r_ref_lines))) begin
                        r_state   <= SEARCH;
                        locked    <= 1'b0;
                        lock_lost <= 1'b1;
                    end
                end
                default: begin
                    r_state <= SEARCH;
                    locked  <= 1'b0;
                end
            endcase

`ifdef VGA_SYNC_TIMEOUT_EN
            if (w_h_sat && r_state != SEARCH) begin
                r_state   <= SEARCH;
                locked    <= 1'b0;
                lock_lost <= (r_state == LOCKED);
            end
`endif
        end
    end

    assign pixel_x = r_h_counter;
    assign pixel_y = r_v_counter;

endmodule
